// File: rtl/serial_sub_pkg.sv
// Shared types and sizing for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The bit counter runs 0..w-1, so clog2(w) bits suffice (never below 1).
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// One-bit full subtractor: d = x - y - bin, br = borrow out.
module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic br
);

  assign d  = x ^ y ^ bin;
  assign br = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB-first, one bit per SHIFT cycle.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output state_t           state_dbg
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is taken only while IDLE (busy=0, done=0); busy stays high
  // for the WIDTH processing cycles; done pulses for one cycle with diff/bout valid,
  // and diff/bout then hold until the next result lands.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, bout_q;
  logic [CW-1:0]    cnt_q;
  logic             step_d, step_br;
  logic             last_bit;

  fs_bit u_fs_bit (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bin (borrow_q),
    .d   (step_d),
    .br  (step_br)
  );

  assign last_bit = (cnt_q == LAST);
  assign res_next = {step_d, res_sr[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_q <= bin;
            res_sr   <= '0;
            cnt_q    <= '0;
          end
        end
        SHIFT: begin
          res_sr   <= res_next;
          borrow_q <= step_br;
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // The last step's bit and borrow go straight to the held outputs.
          if (last_bit) begin
            diff_q <= res_next;
            bout_q <= step_br;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic         clk, rst, start, bin;
  logic [W-1:0] a, b, diff;
  logic         busy, done, bout;
  state_t       state_dbg;

  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_done = -1;
  bit chk_interval = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .state_dbg (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  // scoreboard: every done pulse consumes one expected result
  always @(negedge clk) begin
    logic [W:0] e;
    cyc++;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e[W-1:0]));
        check("bout", 32'(bout), 32'(e[W]));
      end
      if (chk_interval && last_done >= 0) check("done_interval", 32'(cyc - last_done), 32'd10);
      last_done = cyc;
    end
  end

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; bin = c; start = 1'b1;
    exp_q.push_back(model(x, y, c));
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    int j;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // latency: busy for 8 cycles, done in the 9th after the accepting edge
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h5A, 8'h3C, 1'b0));
    @(negedge clk);
    start = 1'b0;
    j = 1;
    check("busy_first", 32'(busy), 32'd1);
    while (!done && j < 30) begin
      @(negedge clk);
      j++;
      if (j == 8) check("busy_last", 32'(busy), 32'd1);
    end
    check("done_latency", 32'(j), 32'd9);
    check("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("back_to_idle", 32'(state_dbg), 32'(IDLE));

    // directed operand patterns, including wrap-around and borrow-in
    run_op(8'h3C, 8'h5A, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h00, 1'b0);

    // start during SHIFT is ignored and operand changes after capture are harmless
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h5A, 8'h3C, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h01; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("ignored_not_queued", 32'(exp_q.size()), 32'd0);
    repeat (12) @(negedge clk);

    // reset mid-SHIFT aborts with no done pulse
    a = 8'h3C; b = 8'h5A; bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h3C, 8'h5A, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(8'h77, 8'h22, 1'b1);

    // random back-to-back with start held high
    @(negedge clk);
    chk_interval = 1'b1;
    last_done = -1;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      bin = 1'($urandom_range(0, 1));
      start = 1'b1;
      exp_q.push_back(model(a, b, bin));
      @(negedge clk);
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      bin = 1'($urandom_range(0, 1));
      if (i == 999) start = 1'b0;
      repeat (9) @(negedge clk);
    end
    j = 0;
    while (exp_q.size() != 0 && j < 50) begin
      @(negedge clk);
      j++;
    end
    chk_interval = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request a new subtraction; sampled only in IDLE.
REQ-006 Port: a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-007 Port: b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-008 Port: bin  input  1  borrow-in; captured on the accepted start edge.
REQ-009 Port: busy  output  1  high while bits are being processed.
REQ-010 Port: done  output  1  one-cycle pulse when the result is valid.
REQ-011 Port: diff  output  WIDTH  result a-b-bin modulo 2^WIDTH; held until the next accepted start.
REQ-012 Port: bout  output  1  final borrow-out; held with diff.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1: capture a, b and bin into the operand shift registers and borrow flop, clear the bit counter, and go to SHIFT.
REQ-015 In each SHIFT cycle the block SHALL perform one LSB-first full-subtract step:
- inputs: a_sr[0], b_sr[0], borrow flop.
- d = a^b^c.
- br = (~a&b)|(~a&c)|(b&c).
REQ-016 In each SHIFT cycle, d SHALL shift into the MSB of the result shift register, br SHALL load into the borrow flop, both operand registers SHALL shift right, and the counter SHALL increment.
REQ-017 When the counter reaches WIDTH-1 in SHIFT, the next state SHALL be DONE.
- SHIFT lasts exactly WIDTH cycles.
REQ-018 On the transition into DONE, the result register SHALL load into diff and the final borrow SHALL load into bout.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 Output decode:
- busy=1 exactly in SHIFT.
- done=1 exactly in DONE.
- both outputs registered or decoded from registered state; no combinational path from start.
REQ-021 Latency: with start accepted at edge T, busy is high from T+1 through T+WIDTH, and done is high during cycle T+WIDTH+1.
REQ-022 Start asserted in SHIFT or DONE SHALL be ignored (not queued).
- a, b and bin changes after capture SHALL NOT affect the result.
REQ-023 Back-to-back: start held high SHALL be accepted in the IDLE cycle after DONE.
- Minimum issue interval: WIDTH+2 cycles.
REQ-024 diff and bout SHALL change only on entry to DONE or on reset.
REQ-025 Wrap-around: a result below zero SHALL be reported modulo 2^WIDTH with bout=1.
- bout=1 if and only if a < b+bin, unsigned.

Reset
REQ-026 On rst=1, asynchronously and regardless of state: state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, all shift registers and the borrow flop = 0.
REQ-027 Reset mid-SHIFT SHALL abort the operation with no done pulse.
- The first start after rst deasserts SHALL be handled normally.

Structure
REQ-028 The shared package serial_sub_pkg SHALL hold:
- the FSM state type (IDLE/SHIFT/DONE);
- the default WIDTH constant;
- the counter width as clog2(WIDTH).
REQ-029 The one-bit difference/borrow logic SHALL be a sub-module, fs_bit (inputs x, y, bin; outputs d, br), instantiated once.
REQ-030 No other sub-modules SHALL be used.
- Implementation target: 120-400 lines.

Verification
REQ-031 WIDTH=8, a=0x5A, b=0x3C, bin=0 -> done at T+9, diff=0x1E, bout=0.
REQ-032 a=0x3C, b=0x5A, bin=0 -> diff=0xE2, bout=1; a=0x00, b=0x01 -> diff=0xFF, bout=1.
REQ-033 a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
REQ-034 start pulsed with new operands at T+3 of an in-flight operation -> it is ignored, and the first result is unchanged.
REQ-035 rst asserted at T+4 -> busy=0, diff=0, bout=0 immediately, and no done pulse; a following start produces the correct result.
REQ-036 Random self-check: 1000 back-to-back operations with start held high -> each diff/bout equals the reference model (a-b-bin), and done appears every 10 cycles.
